// File: rtl/dump_ctrl.sv
// dump_ctrl: reads one channel's circular sample buffer out to the UART TX.
// A dump starts at the oldest entry (the capture write pointer), sends
// exactly ENTRIES bytes, waits on the TX handshake for each byte, and
// then pulses clr_capture_done so the capture logic can re-arm.
//
// Ports:
//   clk, rst_n           system clock / asynchronous active-low reset
//   dump_req, dump_chan  dump request pulse and channel select (0..4)
//   capture_done         a dump is only accepted while this is high
//   waddr                capture write pointer (oldest sample location)
//   rdata0..rdata4       per-channel RAM read data, valid the cycle after ren
//   ren, raddr           shared RAM read enable / address
//   tx_data, trmt        byte and start pulse to the UART transmitter
//   tx_done              UART byte complete (pulse or level)
//   dump_busy            high while a dump is in progress, DONE cycle included
//   dump_done            one-cycle pulse after the last byte completes
//   clr_capture_done     one-cycle pulse, coincident with dump_done
//   dump_err             one-cycle pulse after a rejected request
module dump_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_req,
  input  logic [2:0]      dump_chan,
  input  logic            capture_done,
  input  logic [LOG2-1:0] waddr,
  input  logic [7:0]      rdata0,
  input  logic [7:0]      rdata1,
  input  logic [7:0]      rdata2,
  input  logic [7:0]      rdata3,
  input  logic [7:0]      rdata4,
  output logic            ren,
  output logic [LOG2-1:0] raddr,
  output logic [7:0]      tx_data,
  output logic            trmt,
  input  logic            tx_done,
  output logic            dump_busy,
  output logic            dump_done,
  output logic            clr_capture_done,
  output logic            dump_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    LATCH   = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Last valid index; ENTRIES need not be a power of two, so the address
  // wraps by compare rather than by natural overflow.
  localparam logic [LOG2-1:0] LAST      = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   ENTRIES_W = (LOG2 + 1)'(ENTRIES);

  state_t          state_r, state_s;
  logic [LOG2-1:0] addr_r, addr_s;
  logic [LOG2-1:0] cnt_r, cnt_s;
  logic [2:0]      chan_r, chan_s;
  logic            err_s;

  logic            ren_s;
  logic [LOG2-1:0] raddr_s;
  logic [7:0]      tx_data_s;
  logic            trmt_s;
  logic            busy_s;
  logic            done_s;

  // Selects the read data of the latched channel.
  function automatic logic [7:0] sel_byte(input logic [2:0] c,
                                          input logic [7:0] d0,
                                          input logic [7:0] d1,
                                          input logic [7:0] d2,
                                          input logic [7:0] d3,
                                          input logic [7:0] d4);
    logic [7:0] r;
    case (c)
      3'd0:    r = d0;
      3'd1:    r = d1;
      3'd2:    r = d2;
      3'd3:    r = d3;
      3'd4:    r = d4;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      addr_r           <= '0;
      cnt_r            <= '0;
      chan_r           <= 3'd0;
      ren              <= 1'b0;
      raddr            <= '0;
      tx_data          <= 8'h00;
      trmt             <= 1'b0;
      dump_busy        <= 1'b0;
      dump_done        <= 1'b0;
      clr_capture_done <= 1'b0;
      dump_err         <= 1'b0;
    end else begin
      state_r          <= state_s;
      addr_r           <= addr_s;
      cnt_r            <= cnt_s;
      chan_r           <= chan_s;
      ren              <= ren_s;
      raddr            <= raddr_s;
      tx_data          <= tx_data_s;
      trmt             <= trmt_s;
      dump_busy        <= busy_s;
      dump_done        <= done_s;
      clr_capture_done <= done_s;
      dump_err         <= err_s;
    end
  end

  // Next-state, address/count and request-acceptance logic.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    cnt_s   = cnt_r;
    chan_s  = chan_r;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (dump_req) begin
          if ((dump_chan <= 3'd4) && capture_done) begin
            chan_s  = dump_chan;
            cnt_s   = '0;
            state_s = READ;
            // An out-of-range write pointer restarts the walk at entry 0.
            if ({1'b0, waddr} >= ENTRIES_W) begin
              addr_s = '0;
            end else begin
              addr_s = waddr;
            end
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ:  state_s = LATCH;
      LATCH: state_s = SEND;
      SEND:  state_s = WAIT_TX;
      WAIT_TX: begin
        // tx_done only counts here, so an early or lingering level
        // from the previous byte cannot advance the walk.
        if (tx_done) begin
          if (cnt_r == LAST) begin
            state_s = DONE;
          end else begin
            state_s = READ;
            cnt_s   = cnt_r + LOG2'(1);
            if (addr_r == LAST) begin
              addr_s = '0;
            end else begin
              addr_s = addr_r + LOG2'(1);
            end
          end
        end else begin
          state_s = WAIT_TX;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the next state, so outputs are registered and
  // line up with the state they belong to.
  always_comb begin
    ren_s  = (state_s == READ);
    trmt_s = (state_s == SEND);
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
    if (state_s == READ) begin
      raddr_s = addr_s;
    end else begin
      raddr_s = raddr;
    end
    // RAM data for this byte is valid during LATCH; otherwise hold.
    if (state_r == LATCH) begin
      tx_data_s = sel_byte(chan_r, rdata0, rdata1, rdata2, rdata3, rdata4);
    end else begin
      tx_data_s = tx_data;
    end
  end

endmodule

// File: tb/tb_dump_ctrl.sv
// Directed bench for dump_ctrl with ENTRIES=8 (LOG2=4 so that an
// out-of-range write pointer can be presented).
module tb_dump_ctrl;

  localparam int ENTRIES = 8;
  localparam int LOG2    = 4;

  logic            clk, rst_n;
  logic            dump_req, capture_done, tx_done;
  logic [2:0]      dump_chan;
  logic [LOG2-1:0] waddr;
  logic [7:0]      rdata [5];
  logic            ren, trmt, dump_busy, dump_done, clr_capture_done, dump_err;
  logic [LOG2-1:0] raddr;
  logic [7:0]      tx_data;

  logic [7:0] mem [5][16];

  int errors = 0;
  int checks = 0;
  int ren_cnt, trmt_cnt, done_cnt, clr_cnt, err_cnt, pair_bad;
  logic [LOG2-1:0] addr_q [$];
  logic [7:0]      data_q [$];
  int tx_delay = 5;
  int tx_hold  = 1;

  dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .dump_chan(dump_chan),
    .capture_done(capture_done), .waddr(waddr),
    .rdata0(rdata[0]), .rdata1(rdata[1]), .rdata2(rdata[2]),
    .rdata3(rdata[3]), .rdata4(rdata[4]),
    .ren(ren), .raddr(raddr), .tx_data(tx_data), .trmt(trmt),
    .tx_done(tx_done), .dump_busy(dump_busy), .dump_done(dump_done),
    .clr_capture_done(clr_capture_done), .dump_err(dump_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM contents: channel 2 holds 0x10+i, the others 0x40+16*c+i.
  function automatic logic [7:0] exp_byte(input int c, input int a);
    if (c == 2) return 8'(8'h10 + a);
    else        return 8'(8'h40 + 16 * c + a);
  endfunction

  initial begin
    for (int c = 0; c < 5; c++)
      for (int a = 0; a < 16; a++)
        mem[c][a] = exp_byte(c, a);
  end

  // Synchronous-read RAM model, one per channel.
  always @(posedge clk) begin
    if (ren)
      for (int c = 0; c < 5; c++) rdata[c] <= mem[c][raddr];
  end

  // UART responder: tx_done rises tx_delay cycles after trmt, held tx_hold cycles.
  initial begin : uart
    int dly_left;
    int hold_left;
    dly_left = 0;
    hold_left = 0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        dly_left = 0; hold_left = 0; tx_done = 1'b0;
      end else begin
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) tx_done = 1'b0;
        end
        if (dly_left > 0) begin
          dly_left--;
          if (dly_left == 0) begin
            tx_done = 1'b1;
            hold_left = tx_hold;
          end
        end
        if (trmt) dly_left = tx_delay;
      end
    end
  end

  // Output monitor.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ren) begin ren_cnt++; addr_q.push_back(raddr); end
      if (trmt) begin trmt_cnt++; data_q.push_back(tx_data); end
      if (dump_done) done_cnt++;
      if (clr_capture_done) clr_cnt++;
      if (dump_err) err_cnt++;
      if (dump_done != clr_capture_done) pair_bad++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    ren_cnt = 0; trmt_cnt = 0; done_cnt = 0; clr_cnt = 0; err_cnt = 0; pair_bad = 0;
    addr_q.delete();
    data_q.delete();
  endtask

  task automatic run_dump(input string tag, input logic [2:0] ch, input logic [LOG2-1:0] wa,
                          input int dly, input int hld, input bit noise,
                          input logic [LOG2-1:0] start);
    int a;
    clear_mon();
    tx_delay = dly; tx_hold = hld;
    capture_done = 1'b1; waddr = wa; dump_chan = ch; dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    waddr = 4'd5;  // pointer moves after acceptance; must not matter
    check_val({tag, "_ren_first"}, 32'(ren), 32'd1);
    check_val({tag, "_raddr_first"}, 32'(raddr), 32'(start));
    check_val({tag, "_busy"}, 32'(dump_busy), 32'd1);
    @(posedge clk); #1;
    check_val({tag, "_ren_latch"}, 32'(ren), 32'd0);
    @(posedge clk); #1;
    check_val({tag, "_trmt_first"}, 32'(trmt), 32'd1);
    check_val({tag, "_data_first"}, 32'(tx_data), 32'(exp_byte(ch, start)));
    for (int i = 0; i < 3000; i++) begin
      dump_req = 1'b0;
      if (dump_done) break;
      if (noise && (i % 6 == 2)) begin
        dump_req = 1'b1;
        dump_chan = (i % 12 == 2) ? 3'd4 : 3'd6;
      end
      @(posedge clk); #1;
    end
    dump_req = 1'b0;
    check_val({tag, "_done_seen"}, 32'(dump_done), 32'd1);
    check_val({tag, "_clr_with_done"}, 32'(clr_capture_done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_ren_count"}, 32'(ren_cnt), 32'd8);
    check_val({tag, "_trmt_count"}, 32'(trmt_cnt), 32'd8);
    check_val({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check_val({tag, "_clr_count"}, 32'(clr_cnt), 32'd1);
    check_val({tag, "_pair"}, 32'(pair_bad), 32'd0);
    check_val({tag, "_err_count"}, 32'(err_cnt), 32'd0);
    check_val({tag, "_busy_end"}, 32'(dump_busy), 32'd0);
    for (int k = 0; k < 8; k++) begin
      a = int'(start) + k;
      if (a >= ENTRIES) a = a - ENTRIES;
      check_val({tag, "_raddr_seq"}, (k < addr_q.size()) ? 32'(addr_q[k]) : 32'hFFFF, 32'(a));
      check_val({tag, "_data_seq"}, (k < data_q.size()) ? 32'(data_q[k]) : 32'hFFFF,
                32'(exp_byte(ch, a)));
      if (k == 7)
        check_val({tag, "_data_hold"}, 32'(tx_data), 32'(exp_byte(ch, a)));
    end
  endtask

  task automatic reject(input string tag, input logic [2:0] ch, input logic cd);
    capture_done = cd; dump_chan = ch; waddr = 4'd2; dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    check_val({tag, "_err"}, 32'(dump_err), 32'd1);
    check_val({tag, "_busy"}, 32'(dump_busy), 32'd0);
    @(posedge clk); #1;
    check_val({tag, "_err_clear"}, 32'(dump_err), 32'd0);
    capture_done = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; dump_req = 1'b0; dump_chan = 3'd0; capture_done = 1'b0; waddr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ren", 32'(ren), 32'd0);
    check_val("rst_raddr", 32'(raddr), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_trmt", 32'(trmt), 32'd0);
    check_val("rst_busy", 32'(dump_busy), 32'd0);
    check_val("rst_done", 32'(dump_done), 32'd0);
    check_val("rst_clr", 32'(clr_capture_done), 32'd0);
    check_val("rst_err", 32'(dump_err), 32'd0);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_dump("wrap", 3'd2, 4'd3, 5, 1, 1'b0, 4'd3);
    run_dump("nowrap", 3'd0, 4'd0, 5, 1, 1'b0, 4'd0);

    clear_mon();
    reject("badchan", 3'd5, 1'b1);
    reject("nocapt", 3'd1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_val("rej_ren_count", 32'(ren_cnt), 32'd0);
    check_val("rej_trmt_count", 32'(trmt_cnt), 32'd0);
    check_val("rej_err_count", 32'(err_cnt), 32'd2);

    run_dump("noise", 3'd1, 4'd6, 4, 1, 1'b1, 4'd6);
    run_dump("txhold", 3'd3, 4'd7, 3, 4, 1'b0, 4'd7);
    run_dump("oorwaddr", 3'd4, 4'd12, 2, 1, 1'b0, 4'd0);

    // Reset in WAIT_TX of the fourth byte.
    clear_mon();
    tx_delay = 6; tx_hold = 1;
    capture_done = 1'b1; waddr = 4'd1; dump_chan = 3'd2; dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (trmt_cnt >= 4) break;
      @(posedge clk); #1;
    end
    check_val("rst4_reach", 32'(trmt_cnt), 32'd4);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst4_ren", 32'(ren), 32'd0);
    check_val("rst4_raddr", 32'(raddr), 32'd0);
    check_val("rst4_tx_data", 32'(tx_data), 32'd0);
    check_val("rst4_trmt", 32'(trmt), 32'd0);
    check_val("rst4_busy", 32'(dump_busy), 32'd0);
    check_val("rst4_done", 32'(dump_done), 32'd0);
    check_val("rst4_clr", 32'(clr_capture_done), 32'd0);
    check_val("rst4_err", 32'(dump_err), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst4_no_done", 32'(done_cnt), 32'd0);
    check_val("rst4_no_clr", 32'(clr_cnt), 32'd0);
    run_dump("after_rst", 3'd2, 4'd5, 5, 1, 1'b0, 4'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
